// File: rtl/array_swap_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_swap_seq_pkg
//  Description : Shared types for the word-serial arraySwap executor.
//  Revision    : 1.0  initial release
// ============================================================================
package array_swap_seq_pkg;

    localparam int c_addr_w = 16;
    localparam int c_len_w  = 16;
    localparam int c_data_w = 32;

    typedef struct packed {
        logic [c_addr_w-1:0] addr_a;
        logic [c_addr_w-1:0] addr_b;
        logic [c_len_w-1:0]  len;
    } arraySwapCmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_DONE = 3'd5
    } arraySwapSeqState_e;

endpackage
`default_nettype wire

// File: rtl/array_swap_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : array_swap_seq_if
//  Description : Command handshake plus single-port u32 memory bus.
//  Revision    : 1.0  initial release
// ============================================================================
interface array_swap_seq_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr_a;
    logic [ADDR_W-1:0] cmd_addr_b;
    logic [LEN_W-1:0]  cmd_len;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;

    // Master is the issuer/memory side, slave is the swap engine.
    modport master (
        output cmd_valid, cmd_addr_a, cmd_addr_b, cmd_len, mem_rdata,
        input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_addr_a, cmd_addr_b, cmd_len, mem_rdata,
        output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/array_swap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : array_swap_seq
//  Description : Multi-cycle arraySwap executor, four memory accesses per word.
//  Revision    : 1.0  initial release
// ============================================================================
module array_swap_seq
    import array_swap_seq_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int LEN_W  = c_len_w,
    parameter int DATA_W = c_data_w
) (
    input  wire logic       clk,
    input  wire logic       rst,
    array_swap_seq_if.slave bus
);

    arraySwapSeqState_e r_state;
    logic [ADDR_W-1:0]  r_addr_a;
    logic [ADDR_W-1:0]  r_addr_b;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_index;
    logic [DATA_W-1:0]  r_tmp_a;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic               r_wdata_pass;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_done;

    logic [LEN_W:0]     w_index_inc;
    logic               w_last;
    logic [ADDR_W-1:0]  w_off;
    logic [ADDR_W-1:0]  w_off_inc;

    // One extra bit so len = 2^LEN_W-1 terminates without index overflow.
    assign w_index_inc = {1'b0, r_index} + (LEN_W+1)'(1);
    assign w_last      = (w_index_inc == {1'b0, r_len});
    assign w_off       = ADDR_W'(r_index);
    assign w_off_inc   = ADDR_W'(w_index_inc[LEN_W-1:0]);

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    // Word B arrives in WR_A and is written straight back to address A.
    assign bus.mem_wdata = r_wdata_pass ? bus.mem_rdata : r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_len        <= '0;
            r_index      <= '0;
            r_tmp_a      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_wdata_pass <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_addr_a    <= bus.cmd_addr_a;
                        r_addr_b    <= bus.cmd_addr_b;
                        r_len       <= bus.cmd_len;
                        r_index     <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_RD_A;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= bus.cmd_addr_a;
                        end
                    end
                end
                ST_RD_A: begin
                    r_state    <= ST_RD_B;
                    r_mem_addr <= r_addr_b + w_off;
                end
                ST_RD_B: begin
                    r_tmp_a      <= bus.mem_rdata;
                    r_state      <= ST_WR_A;
                    r_mem_we     <= 1'b1;
                    r_mem_addr   <= r_addr_a + w_off;
                    r_wdata_pass <= 1'b1;
                end
                ST_WR_A: begin
                    r_state      <= ST_WR_B;
                    r_wdata_pass <= 1'b0;
                    r_mem_addr   <= r_addr_b + w_off;
                    r_mem_wdata  <= r_tmp_a;
                end
                ST_WR_B: begin
                    r_index     <= w_index_inc[LEN_W-1:0];
                    r_mem_we    <= 1'b0;
                    r_mem_wdata <= '0;
                    if (w_last) begin
                        r_state    <= ST_DONE;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= ST_RD_A;
                        r_mem_addr <= r_addr_a + w_off_inc;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_mem_req    <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_wdata_pass <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_array_swap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_swap_seq
//  Description : Self-checking bench: vector table, access scoreboard, corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_swap_seq;
    import array_swap_seq_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        arraySwapCmd_t    cmd;
        int               lat;
        logic [3:0][31:0] va;
        logic [3:0][31:0] vb;
        logic [3:0][31:0] ea;
        logic [3:0][31:0] eb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem [0:65535];
    logic [31:0] gm  [0:65535];
    logic [31:0] r_rdata = '0;
    logic        bk_we = 1'b0;
    logic [15:0] bk_addr = '0;
    logic [31:0] bk_data = '0;
    acc_t        exp_q[$];
    acc_t        e_acc;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    array_swap_seq_if #(.ADDR_W(16), .LEN_W(16), .DATA_W(32)) bus ();

    array_swap_seq #(.ADDR_W(16), .LEN_W(16), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rdata = r_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: one-cycle read latency, backdoor preload port.
    always @(posedge clk) begin
        if (bk_we)
            mem[bk_addr] <= bk_data;
        else if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1)
            mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0)
            r_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected access", 64'(bus.mem_addr), 64'hDEAD);
            end else begin
                e_acc = exp_q.pop_front();
                chk("access we", 64'(bus.mem_we), 64'(e_acc.we));
                chk("access addr", 64'(bus.mem_addr), 64'(e_acc.addr));
                if (e_acc.we)
                    chk("access wdata", 64'(bus.mem_wdata), 64'(e_acc.data));
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bk_we   = 1'b1;
        bk_addr = a;
        bk_data = d;
        gm[a]   = d;
        @(posedge clk);
        #1 bk_we = 1'b0;
    endtask

    // Sequential per-index swap reference producing the expected access stream.
    task automatic push_model(input arraySwapCmd_t c);
        logic [15:0] pa, pb;
        logic [31:0] ra, rb;
        for (int i = 0; i < int'(c.len); i++) begin
            pa = c.addr_a + 16'(i);
            pb = c.addr_b + 16'(i);
            ra = gm[pa];
            rb = gm[pb];
            exp_q.push_back('{we: 1'b0, addr: pa, data: 32'h0});
            exp_q.push_back('{we: 1'b0, addr: pb, data: 32'h0});
            exp_q.push_back('{we: 1'b1, addr: pa, data: rb});
            exp_q.push_back('{we: 1'b1, addr: pb, data: ra});
            gm[pa] = rb;
            gm[pb] = ra;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        chk({tag, " mem_req"},   64'(bus.mem_req),   64'd0);
        chk({tag, " mem_we"},    64'(bus.mem_we),    64'd0);
        chk({tag, " mem_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, " busy"},      64'(bus.busy),      64'd0);
        chk({tag, " done"},      64'(bus.done),      64'd0);
    endtask

    task automatic do_cmd(input arraySwapCmd_t c, input int lat);
        int cyc;
        push_model(c);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr_a = c.addr_a;
        bus.cmd_addr_b = c.addr_b;
        bus.cmd_len    = c.len;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        chk("busy after accept", 64'(bus.busy), 64'd1);
        chk("ready after accept", 64'(bus.cmd_ready), 64'd0);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 4 * int'(c.len) + 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("done seen", 64'(bus.done), 64'd1);
        chk("done cycle", 64'(cyc), 64'(lat));
        @(posedge clk);
        #1;
        chk("done is one cycle", 64'(bus.done), 64'd0);
        chk("ready after done", 64'(bus.cmd_ready), 64'd1);
        chk("accesses outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [3:0][31:0] w4(input int d0, input int d1, input int d2, input int d3);
        return {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] len,
                                input int lat, input logic [3:0][31:0] va, input logic [3:0][31:0] vb,
                                input logic [3:0][31:0] ea, input logic [3:0][31:0] eb);
        vec_t v;
        v.cmd.addr_a = a;
        v.cmd.addr_b = b;
        v.cmd.len    = len;
        v.lat = lat;
        v.va = va;
        v.vb = vb;
        v.ea = ea;
        v.eb = eb;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tbl[6];
        arraySwapCmd_t c;
        logic [15:0]   p;
        int            cyc;
        logic          ready_seen;

        bus.cmd_valid  = 1'b0;
        bus.cmd_addr_a = '0;
        bus.cmd_addr_b = '0;
        bus.cmd_len    = '0;

        tbl[0] = mk(16'h0000, 16'h0040, 16'd2, 9,
                    w4(10, 11, 12, 13), w4(0, 0, 0, 0),
                    w4(0, 0, 12, 13), w4(10, 11, 0, 0));
        tbl[1] = mk(16'h0002, 16'h0045, 16'd3, 13,
                    w4(-24, 47, 26, 99), w4(57, -375, 357, 77),
                    w4(57, -375, 357, 99), w4(-24, 47, 26, 77));
        tbl[2] = mk(16'h0008, 16'h0014, 16'd0, 1,
                    w4(1, 2, 3, 4), w4(5, 6, 7, 8),
                    w4(1, 2, 3, 4), w4(5, 6, 7, 8));
        tbl[3] = mk(16'h0000, 16'h0001, 16'd3, 13,
                    w4(1, 2, 3, 4), w4(2, 3, 4, 9),
                    w4(2, 3, 4, 1), w4(3, 4, 1, 9));
        tbl[4] = mk(16'h0005, 16'h0005, 16'd2, 9,
                    w4(50, 51, 52, 53), w4(50, 51, 52, 53),
                    w4(50, 51, 52, 53), w4(50, 51, 52, 53));
        tbl[5] = mk(16'hFFFF, 16'h0010, 16'd2, 9,
                    w4(100, 101, 102, 103), w4(200, 201, 202, 203),
                    w4(200, 201, 102, 103), w4(100, 101, 202, 203));

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) poke(tbl[v].cmd.addr_a + 16'(k), tbl[v].va[k]);
            for (int k = 0; k < 4; k++) poke(tbl[v].cmd.addr_b + 16'(k), tbl[v].vb[k]);
            do_cmd(tbl[v].cmd, tbl[v].lat);
            for (int k = 0; k < 4; k++) begin
                p = tbl[v].cmd.addr_a + 16'(k);
                chk($sformatf("vec%0d mem a+%0d", v, k), 64'(mem[p]), 64'(tbl[v].ea[k]));
                p = tbl[v].cmd.addr_b + 16'(k);
                chk($sformatf("vec%0d mem b+%0d", v, k), 64'(mem[p]), 64'(tbl[v].eb[k]));
            end
        end

        // Second command held valid during the first must wait for IDLE.
        poke(16'd32, 32'hA); poke(16'd40, 32'hB);
        poke(16'd48, 32'hC); poke(16'd56, 32'hD);
        c = '{addr_a: 16'd32, addr_b: 16'd40, len: 16'd1};
        push_model(c);
        c = '{addr_a: 16'd48, addr_b: 16'd56, len: 16'd1};
        push_model(c);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr_a = 16'd32;
        bus.cmd_addr_b = 16'd40;
        bus.cmd_len    = 16'd1;
        @(posedge clk);
        #1;
        bus.cmd_addr_a = 16'd48;
        bus.cmd_addr_b = 16'd56;
        cyc = 1;
        ready_seen = 1'b0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.cmd_ready === 1'b1) ready_seen = 1'b1;
            @(posedge clk);
            #1 cyc++;
        end
        chk("b2b first done cycle", 64'(cyc), 64'd5);
        chk("b2b ready during busy", 64'(ready_seen), 64'd0);
        chk("b2b ready in done", 64'(bus.cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("b2b ready after done", 64'(bus.cmd_ready), 64'd1);
        chk("b2b idle not busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        chk("b2b second accepted", 64'(bus.busy), 64'd1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("b2b second done cycle", 64'(cyc), 64'd5);
        @(posedge clk);
        #1;
        chk("b2b accesses outstanding", 64'(exp_q.size()), 64'd0);
        chk("b2b mem32", 64'(mem[32]), 64'hB);
        chk("b2b mem40", 64'(mem[40]), 64'hA);
        chk("b2b mem48", 64'(mem[48]), 64'hD);
        chk("b2b mem56", 64'(mem[56]), 64'hC);

        // Asynchronous reset in WR_A of word 1 of a 3-word swap.
        poke(16'd100, 32'd1); poke(16'd101, 32'd2); poke(16'd102, 32'd3);
        poke(16'd200, 32'd7); poke(16'd201, 32'd8); poke(16'd202, 32'd9);
        c = '{addr_a: 16'd100, addr_b: 16'd200, len: 16'd3};
        push_model(c);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr_a = 16'd100;
        bus.cmd_addr_b = 16'd200;
        bus.cmd_len    = 16'd3;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("rst-test in WR_A we", 64'(bus.mem_we), 64'd1);
        chk("rst-test in WR_A addr", 64'(bus.mem_addr), 64'd101);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst-test mem100", 64'(mem[100]), 64'd7);
        chk("rst-test mem200", 64'(mem[200]), 64'd1);
        chk("rst-test mem101", 64'(mem[101]), 64'd2);
        chk("rst-test mem201", 64'(mem[201]), 64'd8);
        chk("rst-test mem102", 64'(mem[102]), 64'd3);
        chk("rst-test mem202", 64'(mem[202]), 64'd9);
        chk("rst-test idle mem_req", 64'(bus.mem_req), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
